// File: rtl/shift_seq.sv
// Iterative N-position shifter: one bit position per clock, valid/ready on both sides.
module shift_seq #(
  parameter int unsigned W  = 8,
  parameter int unsigned AW = $clog2(W) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  a,
  input  logic [AW-1:0] amt,
  input  logic          dir,
  input  logic          arith,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  y,
  output logic          busy
);

  // Counter must be able to hold W itself (the clamped maximum).
  localparam int unsigned CW = $clog2(W + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [W-1:0]  y_q, y_d;
  logic [CW-1:0] count_q, count_d;
  logic          dir_q, dir_d;
  logic          arith_q, arith_d;
  logic          in_ready_q, in_ready_d;
  logic          out_valid_q, out_valid_d;
  logic          busy_q, busy_d;

  logic          accept;
  logic [CW-1:0] amt_clamped;

  assign accept = in_valid && in_ready_q;

  // Amounts beyond W are equivalent to W: every bit has been shifted out by then.
  always_comb begin
    amt_clamped = CW'(W);
    if (32'(amt) < W) begin
      amt_clamped = CW'(amt);
    end
  end

  // Next-state, datapath step and registered-output next values.
  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    count_d = count_q;
    dir_d   = dir_q;
    arith_d = arith_q;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          y_d     = a;
          dir_d   = dir;
          arith_d = arith;
          count_d = amt_clamped;
          state_d = (amt_clamped == '0) ? ST_DONE : ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (!dir_q) begin
          y_d = {y_q[W-2:0], 1'b0};
        end else if (arith_q) begin
          y_d = {y_q[W-1], y_q[W-1:1]};
        end else begin
          y_d = {1'b0, y_q[W-1:1]};
        end
        count_d = count_q - CW'(1);
        if (count_q == CW'(1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Handshake outputs track the state being entered so they are flop outputs.
    in_ready_d  = (state_d == ST_IDLE);
    out_valid_d = (state_d == ST_DONE);
    busy_d      = (state_d != ST_IDLE);
  end

  // State and output registers; reset clears everything immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      y_q         <= '0;
      count_q     <= '0;
      dir_q       <= 1'b0;
      arith_q     <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      y_q         <= y_d;
      count_q     <= count_d;
      dir_q       <= dir_d;
      arith_q     <= arith_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign y         = y_q;

endmodule

// File: tb/tb_shift_seq.sv
// Directed bench for shift_seq (W=8, AW=4) with hand-computed expectations.
module tb_shift_seq;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [3:0] amt;
  logic       dir;
  logic       arith;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] y;
  logic       busy;

  int checks;
  int errors;

  shift_seq #(.W(8), .AW(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .amt       (amt),
    .dir       (dir),
    .arith     (arith),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issue one command, measure edges to out_valid, check result, then drain it.
  task automatic run_cmd(input string tag, input logic [7:0] ta, input logic [3:0] tamt,
                         input logic td, input logic tar, input logic [7:0] ey, input int ek);
    int n;
    @(negedge clk);
    check({tag, "_rdy"}, 32'(in_ready), 32'd1);
    a = ta; amt = tamt; dir = td; arith = tar; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = ~ta; amt = 4'd3; dir = ~td;  // changes while busy must be ignored
    n = 0;
    while (!out_valid && n < 20) begin
      check({tag, "_busy"}, 32'(busy), 32'd1);
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_lat"}, 32'(n), 32'(ek));
    check({tag, "_y"}, 32'(y), 32'(ey));
    check({tag, "_busy_done"}, 32'(busy), 32'd1);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_ov_drop"}, 32'(out_valid), 32'd0);
    check({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    checks = 0; errors = 0;
    rst_n = 1'b0; in_valid = 1'b0; a = '0; amt = '0; dir = 1'b0; arith = 1'b0; out_ready = 1'b0;

    // Reset values
    #12;
    check("rst_ready", 32'(in_ready), 32'd0);
    check("rst_ov", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_y", 32'(y), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_ready", 32'(in_ready), 32'd1);

    run_cmd("t1_left1",   8'b10101010, 4'd1,  1'b0, 1'b0, 8'b01010100, 1);
    run_cmd("t2_lsr3",    8'b00110011, 4'd3,  1'b1, 1'b0, 8'b00000110, 3);
    run_cmd("t3_asr2",    8'b10110000, 4'd2,  1'b1, 1'b1, 8'b11101100, 2);
    run_cmd("t3_lsl2_ar", 8'b10110000, 4'd2,  1'b0, 1'b1, 8'b11000000, 2);
    run_cmd("t4_amt0",    8'h5A,       4'd0,  1'b1, 1'b1, 8'h5A,       0);
    run_cmd("t4_asr12",   8'hFF,       4'd12, 1'b1, 1'b1, 8'hFF,       8);
    run_cmd("t4_lsr12",   8'hFF,       4'd12, 1'b1, 1'b0, 8'h00,       8);
    run_cmd("lsl8",       8'hFF,       4'd8,  1'b0, 1'b0, 8'h00,       8);
    run_cmd("asr7",       8'h80,       4'd7,  1'b1, 1'b1, 8'hFF,       7);
    run_cmd("lsr15",      8'h81,       4'd15, 1'b1, 1'b0, 8'h00,       8);

    // Backpressure: hold DONE with a pending new command
    @(negedge clk);
    a = 8'hC3; amt = 4'd1; dir = 1'b1; arith = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    a = 8'h3C; amt = 4'd0;  // new command waiting, in_valid stays high
    @(posedge clk); #1;
    check("bp_enter", 32'(out_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_y", 32'(y), 32'h61);
      check("bp_ov", 32'(out_valid), 32'd1);
      check("bp_rdy", 32'(in_ready), 32'd0);
    end
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_release_ov", 32'(out_valid), 32'd0);
    check("bp_release_rdy", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_next_ov", 32'(out_valid), 32'd1);
    check("bp_next_y", 32'(y), 32'h3C);
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_next_drain", 32'(out_valid), 32'd0);

    // Asynchronous reset during SHIFT
    @(negedge clk);
    a = 8'hF0; amt = 4'd6; dir = 1'b0; arith = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("ar_busy_pre", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("ar_ov", 32'(out_valid), 32'd0);
    check("ar_y", 32'(y), 32'd0);
    check("ar_busy", 32'(busy), 32'd0);
    check("ar_rdy", 32'(in_ready), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("ar_rdy_after", 32'(in_ready), 32'd1);
    run_cmd("ar_fresh", 8'h96, 4'd4, 1'b1, 1'b1, 8'hF9, 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
